data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
- Multi-cycle data memory that answers the load/store requests of the single-cycle CPU.
- It drives BUSYWAIT, which stalls the PC and inhibits register-file writeback while an access is in flight.
- Requests are sampled and latched, the access takes a fixed number of cycles, and completion is signalled by dropping BUSYWAIT for one ACK cycle.
- It sits between the ALU result (address), the register-file read port (store data) and the writeback mux (load data).

Parameters:
ADDR_WIDTH, 8, address width; memory depth = 2**ADDR_WIDTH bytes.
DATA_WIDTH, 8, width of one memory word.
ACCESS_CYCLES, 5, cycles spent in ACCESS state; legal range 1..15.

Ports:
CLK  input  1  system clock, all state updates on posedge.
RESET  input  1  synchronous, active-high reset.
READ  input  1  load request, level, held by CPU until it sees BUSYWAIT low.
WRITE  input  1  store request, level, same rules as READ.
ADDRESS  input  ADDR_WIDTH  byte address of access.
WRITEDATA  input  DATA_WIDTH  store data.
READDATA  output  DATA_WIDTH  load result, registered.
BUSYWAIT  output  1  stall to CPU / register file.

Behaviour:
- Interface: one clock, CLK. Reset is RESET, synchronous and active-high.
- States: IDLE, ACCESS, ACK. State, counter, latched op/address/data and READDATA are all registers.
- Reset: state=IDLE, counter=0, READDATA=0. BUSYWAIT is forced to 0 combinationally while RESET=1.
- A reset asserted in ACCESS aborts the access: a pending write is discarded and memory is not modified.
- Memory array contents are not affected by reset, except under the Optional Feature.
- BUSYWAIT, combinational:
  - IDLE: BUSYWAIT = READ XOR WRITE.
  - ACCESS: BUSYWAIT = 1.
  - ACK: BUSYWAIT = 0.
- IDLE, posedge with exactly one of READ/WRITE high:
  - latch ADDRESS, WRITEDATA and the op;
  - counter = ACCESS_CYCLES-1;
  - go to ACCESS.
- IDLE with READ and WRITE both high: illegal. No access, BUSYWAIT=0, stay in IDLE.
- IDLE with neither high: stay in IDLE.
- ACCESS, posedge:
  - if counter != 0: counter decrements.
  - if counter == 0: perform the access on the latched values and go to ACK. A write stores into mem[addr]; a read loads mem[addr] into READDATA.
- ACCESS ignores changes on ADDRESS, WRITEDATA, READ and WRITE; only the latched copies are used.
- ACK: lasts exactly one cycle. Requests are ignored, so the still-high request from the completed access cannot re-trigger. Next posedge goes to IDLE.
- READDATA is valid from the ACK cycle onward and holds until the next completed read. Writes do not change READDATA.
- Latency: the request is asserted in cycle 0 (IDLE) and BUSYWAIT stays high through cycles 0..ACCESS_CYCLES. ACK is cycle ACCESS_CYCLES+1, so total stall = ACCESS_CYCLES+1 cycles.
- Back-to-back accesses: the earliest a new request can be sampled is the IDLE cycle after ACK, giving a minimum spacing of ACCESS_CYCLES+2 cycles between request starts.
- Address wrap: none needed, because the address spans the full depth.
- A read after a write to the same address returns the written value, since the write completed in an earlier ACCESS.

Optional Feature:
- Macro: DMEM_CLEAR_ON_RESET_EN.
- Defined: a posedge with RESET=1 also writes 0 to every location of the memory array in that same cycle.
- Undefined: RESET leaves memory contents untouched; locations never written read as X in simulation.
- All other reset behaviour is identical in both builds.

Test Plan:
- Reset then idle: RESET=1 for 2 cycles -> READDATA=0, BUSYWAIT=0, state IDLE. With DMEM_CLEAR_ON_RESET_EN, a read of address 0x10 returns 0x00.
- Write then read: WRITE=1, ADDRESS=0x2A, WRITEDATA=0xC5 -> BUSYWAIT high for 6 cycles (ACCESS_CYCLES=5), low in ACK. Then READ=1, ADDRESS=0x2A -> READDATA=0xC5 in the ACK cycle, and 0xC5 holds afterward.
- Input instability: during ACCESS of a write to 0x05 with data 0x11, change ADDRESS to 0x06 and WRITEDATA to 0xFF -> mem[0x05]=0x11 and mem[0x06] is unchanged.
- Reset mid-access: WRITE 0x77 to 0x40, assert RESET in the 3rd ACCESS cycle -> BUSYWAIT=0 immediately, state IDLE, and a later read of 0x40 does not return 0x77.
- Illegal request: READ=1 and WRITE=1 together -> BUSYWAIT=0, no state change, memory and READDATA unchanged.
- Held request and ACCESS_CYCLES=1: keep READ=1 across ACK -> exactly one new access starts from IDLE after ACK, not a double trigger. With ACCESS_CYCLES=1, total stall = 2 cycles.

Source files
------------

// File: rtl/data_memory_ctrl_if.sv
// Load/store bus between the CPU datapath and data_memory_ctrl.
// The CPU drives the request side; the memory drives load data and the stall.
interface data_memory_ctrl_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic                  read;
   logic                  write;
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] writedata;
   logic [DATA_WIDTH-1:0] readdata;
   logic                  busywait;

   modport master (
      output read, write, address, writedata,
      input  readdata, busywait
   );

   modport slave (
      input  read, write, address, writedata,
      output readdata, busywait
   );
endinterface

// File: rtl/data_memory_ctrl.sv
// Multi-cycle data memory: latches a load/store, stalls the CPU for ACCESS_CYCLES+1 cycles, then acks.
// Build option DMEM_CLEAR_ON_RESET_EN zeroes the whole array on any reset cycle.
module data_memory_ctrl #(
   parameter int ADDR_WIDTH    = 8,
   parameter int DATA_WIDTH    = 8,
   parameter int ACCESS_CYCLES = 5
) (
   input logic               clk,
   input logic               reset,
   data_memory_ctrl_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACCESS_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ACK    = 2'd2
   } state_t;

   state_t                state_r;
   state_t                next_state_s;
   logic [CNT_W-1:0]      cnt_r;
   logic [CNT_W-1:0]      cnt_next_s;
   logic                  op_write_r;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [DATA_WIDTH-1:0] wdata_r;
   logic [DATA_WIDTH-1:0] readdata_r;
   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic                  req_s;
   logic                  start_s;
   logic                  done_s;
   logic                  busy_s;

   // Both-high is illegal and must look exactly like no request.
   assign req_s = bus.read ^ bus.write;

   // Next-state, counter and stall decode.
   always_comb begin
      next_state_s = state_r;
      cnt_next_s   = cnt_r;
      busy_s       = 1'b0;
      start_s      = 1'b0;
      done_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            busy_s = req_s;
            if (req_s) begin
               start_s      = 1'b1;
               cnt_next_s   = CNT_INIT;
               next_state_s = ST_ACCESS;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            busy_s = 1'b1;
            if (cnt_r != {CNT_W{1'b0}}) begin
               cnt_next_s = cnt_r - 4'd1;
            end else begin
               done_s       = 1'b1;
               next_state_s = ST_ACK;
            end
         end
         ST_ACK: begin
            next_state_s = ST_IDLE;
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // Stall is released the instant reset is applied so the CPU never hangs on an aborted access.
   assign bus.busywait = busy_s & ~reset;
   assign bus.readdata = readdata_r;

   // State, counter, request latch and load-data register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         cnt_r      <= {CNT_W{1'b0}};
         op_write_r <= 1'b0;
         addr_r     <= {ADDR_WIDTH{1'b0}};
         wdata_r    <= {DATA_WIDTH{1'b0}};
         readdata_r <= {DATA_WIDTH{1'b0}};
      end else begin
         state_r <= next_state_s;
         cnt_r   <= cnt_next_s;
         if (start_s) begin
            op_write_r <= bus.write;
            addr_r     <= bus.address;
            wdata_r    <= bus.writedata;
         end
         if (done_s && !op_write_r) begin
            readdata_r <= mem_r[addr_r];
         end
      end
   end

   // Storage array; a reset cycle never commits a pending store.
   always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[ADDR_WIDTH'(i)] <= {DATA_WIDTH{1'b0}};
         end
      end else if (done_s && op_write_r) begin
         mem_r[addr_r] <= wdata_r;
      end
`else
      if (!reset && done_s && op_write_r) begin
         mem_r[addr_r] <= wdata_r;
      end
`endif
   end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: transaction-level memory model, stall-length
// and ack-timing checks, directed corner cases plus randomized traffic.
module tb_data_memory_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;

   logic [7:0] mdl [256];
   bit         known [256];
   logic [7:0] rd_exp;
   bit         rd_known;

   data_memory_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) b5 ();
   data_memory_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) b1 ();

   data_memory_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .ACCESS_CYCLES(5)) dut5 (
      .clk(clk), .reset(reset), .bus(b5)
   );
   data_memory_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .ACCESS_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .bus(b1)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model view of a reset: load data returns to zero, contents survive unless cleared.
   task automatic model_reset();
      rd_exp   = 8'h00;
      rd_known = 1'b1;
`ifdef DMEM_CLEAR_ON_RESET_EN
      for (int i = 0; i < 256; i++) begin
         mdl[i]   = 8'h00;
         known[i] = 1'b1;
      end
`endif
   endtask

   // One complete access on the 5-cycle instance; inputs scrambled while the stall is up.
   task automatic access5(input bit wr, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] pa, input logic [7:0] pd);
      int stall;
      b5.read      = !wr;
      b5.write     = wr;
      b5.address   = a;
      b5.writedata = d;
      #1;
      stall = 0;
      while (b5.busywait === 1'b1 && stall < 40) begin
         stall++;
         tick();
         b5.address   = pa;
         b5.writedata = pd;
         b5.read      = 1'($urandom);
         b5.write     = 1'($urandom);
         #1;
      end
      check("stall_len", stall, 32'd6);
      if (wr) begin
         mdl[a]   = d;
         known[a] = 1'b1;
      end else begin
         rd_known = known[a];
         rd_exp   = mdl[a];
      end
      if (rd_known) check("ack_readdata", b5.readdata, rd_exp);
      b5.read  = 1'b0;
      b5.write = 1'b0;
      tick();
      check("idle_busy", b5.busywait, 1'b0);
      if (rd_known) check("hold_readdata", b5.readdata, rd_exp);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mdl[i]   = 8'h00;
         known[i] = 1'b0;
      end
      b5.read = 1'b0; b5.write = 1'b0; b5.address = 8'h00; b5.writedata = 8'h00;
      b1.read = 1'b0; b1.write = 1'b0; b1.address = 8'h00; b1.writedata = 8'h00;

      // Reset then idle; stall is masked while reset is high even with a request present.
      reset = 1'b1;
      tick();
      b5.read = 1'b1;
      #1 check("busy_in_reset", b5.busywait, 1'b0);
      b5.read = 1'b0;
      tick();
      model_reset();
      reset = 1'b0;
      #1;
      check("rst_readdata", b5.readdata, 8'h00);
      check("rst_busy", b5.busywait, 1'b0);
      check("rst_readdata1", b1.readdata, 8'h00);
      tick();
`ifdef DMEM_CLEAR_ON_RESET_EN
      access5(1'b0, 8'h10, 8'h00, 8'h11, 8'h22);
`endif

      // Write then read back.
      access5(1'b1, 8'h2A, 8'hC5, 8'h2A, 8'hC5);
      access5(1'b0, 8'h2A, 8'h00, 8'h2A, 8'h00);

      // Inputs move to another location mid-access.
      access5(1'b1, 8'h06, 8'h5A, 8'h06, 8'h5A);
      access5(1'b1, 8'h05, 8'h11, 8'h06, 8'hFF);
      access5(1'b0, 8'h05, 8'h00, 8'h06, 8'h00);
      access5(1'b0, 8'h06, 8'h00, 8'h05, 8'h00);

      // Reset in the third ACCESS cycle aborts the store.
      access5(1'b1, 8'h40, 8'h33, 8'h40, 8'h33);
      b5.write = 1'b1; b5.read = 1'b0; b5.address = 8'h40; b5.writedata = 8'h77;
      tick(); tick(); tick();
      reset = 1'b1;
      #1 check("abort_busy", b5.busywait, 1'b0);
      tick();
      model_reset();
      reset    = 1'b0;
      b5.write = 1'b0;
      #1;
      check("abort_idle_busy", b5.busywait, 1'b0);
      check("abort_readdata", b5.readdata, 8'h00);
      tick();
      access5(1'b0, 8'h40, 8'h00, 8'h41, 8'h00);
      check("abort_not_77", (b5.readdata === 8'h77), 1'b0);

      // Both requests high: no access, nothing changes.
      access5(1'b0, 8'h2A, 8'h00, 8'h2A, 8'h00);
      b5.read = 1'b1; b5.write = 1'b1; b5.address = 8'h2A; b5.writedata = 8'h3C;
      for (int c = 0; c < 3; c++) begin
         #1 check("illegal_busy", b5.busywait, 1'b0);
         tick();
      end
      b5.read = 1'b0; b5.write = 1'b0;
      #1 check("illegal_readdata", b5.readdata, rd_exp);
      tick();
      access5(1'b0, 8'h2A, 8'h00, 8'h00, 8'h00);

      // Randomized traffic over a small window so reads often hit written data.
      for (int n = 0; n < 24; n++) begin
         access5(1'($urandom), 8'h80 + 8'($urandom_range(0, 7)), 8'($urandom),
                 8'($urandom), 8'($urandom));
      end

      // ACCESS_CYCLES=1 instance: store, then a held load re-triggers once per period of 3.
      b1.write = 1'b1; b1.address = 8'h10; b1.writedata = 8'h9C;
      for (int c = 0; c < 3; c++) begin
         #1 check("c1_wr_busy", b1.busywait, ((c % 3) != 2));
         if (c == 2) b1.write = 1'b0;
         tick();
      end
      b1.read = 1'b1; b1.address = 8'h10;
      for (int c = 0; c < 9; c++) begin
         #1 check("c1_held_busy", b1.busywait, ((c % 3) != 2));
         if ((c % 3) == 2) check("c1_held_rd", b1.readdata, 8'h9C);
         if (c == 8) b1.read = 1'b0;
         tick();
      end
      #1 check("c1_idle_busy", b1.busywait, 1'b0);
      check("c1_hold_rd", b1.readdata, 8'h9C);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
